// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : mem_arb_pkg                                                |
// | Shared types for the fetch / load-store SRAM port arbiter:           |
// | response owner encoding, response tag layout and the read enable.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    logic   kill;
    owner_e owner;
  } resp_tag_t;

  localparam logic [3:0] WE_READ = 4'b0000;

  localparam resp_tag_t c_tag_empty = '{valid: 1'b0, kill: 1'b0, owner: OWN_IF};

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : mem_port_arbiter_if                                      |
// | Bundles the fetch port, the load/store port and the SRAM macro port. |
// |   fetch : if_req, if_addr, if_flush -> if_gnt, if_stall,             |
// |           if_rvalid, if_rdata                                        |
// |   data  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata   |
// |   sram  : mem_cs, mem_we, mem_addr, mem_wdata <- mem_rdata           |
// | Modport slave is the arbiter; master is the pipeline/SRAM side.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_stall;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic [3:0]        d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_cs;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_stall, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_stall, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_resp_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : resp_tracker                                                |
// | LAT-deep shift register of response tags. A tag enters on every      |
// | granted access and leaves LAT cycles later, aligned with the SRAM    |
// | read data. A flush marks every fetch-owned tag in flight as killed.  |
// |   clk, rst (async, active-low)                                       |
// |   i_push_valid / i_push_owner : tag of this cycle's granted access   |
// |   i_flush                     : kill in-flight fetch tags            |
// |   o_exit_tag                  : tag whose data is on mem_rdata now   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module resp_tracker
  import mem_arb_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_push_valid,
  input  owner_e    i_push_owner,
  input  logic      i_flush,
  output resp_tag_t o_exit_tag
);

  resp_tag_t r_tags [LAT];
  resp_tag_t w_next [LAT];

  always_comb begin
    w_next[0] = '{valid: i_push_valid, kill: 1'b0, owner: i_push_owner};
    for (int i = 1; i < LAT; i++) begin
      w_next[i] = r_tags[i-1];
    end
    // Killing while shifting means a tag flushed in any cycle of its
    // flight stays dead until it exits.
    for (int i = 0; i < LAT; i++) begin
      if (i_flush && (w_next[i].owner == OWN_IF)) begin
        w_next[i].kill = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        r_tags[i] <= c_tag_empty;
      end
    end else begin
      r_tags <= w_next;
    end
  end

  assign o_exit_tag = r_tags[LAT-1];

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : mem_port_arbiter                                            |
// | Shares one single-port fixed-latency SRAM between instruction fetch  |
// | and load/store. Data has default priority; fetch wins after          |
// | STARVE_MAX consecutive lost cycles. Read responses are routed back   |
// | to their requester; a fetch flush discards in-flight fetch reads.    |
// |   clk, rst (async, active-low)                                       |
// |   bus : mem_port_arbiter_if.slave (fetch, data and SRAM ports)       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  logic [2:0]        r_starve;
  logic [DATA_W-1:0] r_if_hold;
  logic [DATA_W-1:0] r_d_hold;

  logic              w_fetch_prio;
  logic              w_if_gnt;
  logic              w_d_gnt;
  logic              w_d_read;
  logic              w_push_valid;
  owner_e            w_push_owner;
  resp_tag_t         w_exit;
  logic              w_if_exit;
  logic              w_d_exit;
  logic [ADDR_W-1:0] w_mem_addr;

  // ---------------- arbitration ----------------
  assign w_fetch_prio = (r_starve == 3'(STARVE_MAX));
  // A flushing fetch stage never gets the port, so data may take it.
  assign w_if_gnt     = bus.if_req & ~bus.if_flush & (~bus.d_req | w_fetch_prio);
  assign w_d_gnt      = bus.d_req & ~w_if_gnt;
  assign w_d_read     = w_d_gnt & (bus.d_we == WE_READ);

  assign bus.if_gnt   = w_if_gnt;
  assign bus.if_stall = bus.if_req & ~w_if_gnt;
  assign bus.d_gnt    = w_d_gnt;

  assign w_mem_addr    = w_if_gnt ? bus.if_addr : bus.d_addr;
  assign bus.mem_cs    = w_if_gnt | w_d_gnt;
  assign bus.mem_we    = w_d_gnt ? bus.d_we : WE_READ;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = bus.d_wdata;

  // Counts cycles fetch lost to data. It saturates at STARVE_MAX so a
  // flush landing on the priority cycle cannot push it past the match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= 3'd0;
    end else if (w_if_gnt || !bus.if_req) begin
      r_starve <= 3'd0;
    end else if (w_d_gnt && !w_fetch_prio) begin
      r_starve <= r_starve + 3'd1;
    end
  end

  // ---------------- response routing ----------------
  assign w_push_valid = w_if_gnt | w_d_read;
  assign w_push_owner = w_if_gnt ? OWN_IF : OWN_D;

  resp_tracker #(
    .LAT (LAT)
  ) u_resp_tracker (
    .clk          (clk),
    .rst          (rst),
    .i_push_valid (w_push_valid),
    .i_push_owner (w_push_owner),
    .i_flush      (bus.if_flush),
    .o_exit_tag   (w_exit)
  );

  // A flush in the exit cycle itself is caught here, not in the tracker.
  assign w_if_exit = w_exit.valid & (w_exit.owner == OWN_IF) & ~w_exit.kill & ~bus.if_flush;
  assign w_d_exit  = w_exit.valid & (w_exit.owner == OWN_D);

  assign bus.if_rvalid = w_if_exit;
  assign bus.if_rdata  = w_if_exit ? bus.mem_rdata : r_if_hold;
  assign bus.d_rvalid  = w_d_exit;
  assign bus.d_rdata   = w_d_exit ? bus.mem_rdata : r_d_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_hold <= '0;
      r_d_hold  <= '0;
    end else begin
      if (w_if_exit) r_if_hold <= bus.mem_rdata;
      if (w_d_exit)  r_d_hold  <= bus.mem_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_mem_port_arbiter                                         |
// | Two arbiters (LAT=1 and LAT=3) driven with identical requests, each  |
// | with its own SRAM read pipeline over one shared 32-word memory.      |
// | Expected values come from a transaction-level model: grant history,  |
// | flush history and a shadow memory.                                   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int LAT_A      = 1;
  localparam int LAT_B      = 3;
  localparam int HIST       = 4096;

  logic        clk;
  logic        rst;
  logic        sram_load;
  logic        tb_if_req, tb_if_flush, tb_d_req;
  logic [4:0]  tb_if_addr, tb_d_addr;
  logic [3:0]  tb_d_we;
  logic [31:0] tb_d_wdata;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT_A), .STARVE_MAX(STARVE_MAX))
    dut_a (.clk(clk), .rst(rst), .bus(bus0));
  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT_B), .STARVE_MAX(STARVE_MAX))
    dut_b (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.if_req   = tb_if_req;              assign bus1.if_req   = tb_if_req;
  assign bus0.if_addr  = {9'd0, tb_if_addr};     assign bus1.if_addr  = {9'd0, tb_if_addr};
  assign bus0.if_flush = tb_if_flush;            assign bus1.if_flush = tb_if_flush;
  assign bus0.d_req    = tb_d_req;               assign bus1.d_req    = tb_d_req;
  assign bus0.d_we     = tb_d_we;                assign bus1.d_we     = tb_d_we;
  assign bus0.d_addr   = {9'd0, tb_d_addr};      assign bus1.d_addr   = {9'd0, tb_d_addr};
  assign bus0.d_wdata  = tb_d_wdata;             assign bus1.d_wdata  = tb_d_wdata;

  // SRAM environment: shared contents, per-instance read latency.
  logic [31:0] init_val [32];
  logic [31:0] sram [32];
  logic [31:0] pa, pb0, pb1, pb2;
  always @(posedge clk) begin
    if (sram_load) begin
      for (int i = 0; i < 32; i++) sram[i] <= init_val[i];
    end else if (bus0.mem_cs && bus0.mem_we != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (bus0.mem_we[b]) sram[bus0.mem_addr[4:0]][b*8 +: 8] <= bus0.mem_wdata[b*8 +: 8];
    end
    if (bus0.mem_cs && bus0.mem_we == 4'b0000) pa  <= sram[bus0.mem_addr[4:0]];
    if (bus1.mem_cs && bus1.mem_we == 4'b0000) pb0 <= sram[bus1.mem_addr[4:0]];
    pb1 <= pb0;
    pb2 <= pb1;
  end
  assign bus0.mem_rdata = pa;
  assign bus1.mem_rdata = pb2;

  logic        o_ifv [2];
  logic        o_dv  [2];
  logic [31:0] o_ifd [2];
  logic [31:0] o_dd  [2];
  assign o_ifv[0] = bus0.if_rvalid;  assign o_ifv[1] = bus1.if_rvalid;
  assign o_dv[0]  = bus0.d_rvalid;   assign o_dv[1]  = bus1.d_rvalid;
  assign o_ifd[0] = bus0.if_rdata;   assign o_ifd[1] = bus1.if_rdata;
  assign o_dd[0]  = bus0.d_rdata;    assign o_dd[1]  = bus1.d_rdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit          h_rd     [HIST];
  bit          h_own_if [HIST];
  bit          h_flush  [HIST];
  logic [31:0] h_data   [HIST];
  logic [31:0] mm [32];
  int          cyc, epoch, m_starve;
  int          n_cmp, n_fail;
  bit          e_if_gnt, e_d_gnt;
  bit          e_ifv [2];
  bit          e_dv  [2];
  logic [31:0] e_ifd [2];
  logic [31:0] e_dd  [2];
  logic [31:0] hold_if [2];
  logic [31:0] hold_d  [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction

  // A read granted in cycle g answers in cycle g+L unless a flush occurred
  // in any cycle g+1 .. g+L (fetch only); reads before the last reset never answer.
  task automatic model_expect();
    int g;
    bit killed;
    h_flush[cyc] = tb_if_flush;
    e_if_gnt = tb_if_req && !tb_if_flush && (!tb_d_req || m_starve == STARVE_MAX);
    e_d_gnt  = tb_d_req && !e_if_gnt;
    for (int k = 0; k < 2; k++) begin
      g = cyc - lat_of(k);
      e_ifv[k] = 1'b0;  e_ifd[k] = hold_if[k];
      e_dv[k]  = 1'b0;  e_dd[k]  = hold_d[k];
      if (g >= epoch && h_rd[g]) begin
        if (h_own_if[g]) begin
          killed = 1'b0;
          for (int j = g + 1; j <= cyc; j++) if (h_flush[j]) killed = 1'b1;
          if (!killed) begin e_ifv[k] = 1'b1; e_ifd[k] = h_data[g]; end
        end else begin
          e_dv[k] = 1'b1; e_dd[k] = h_data[g];
        end
      end
    end
  endtask

  task automatic model_commit();
    logic [4:0] a;
    a = e_if_gnt ? tb_if_addr : tb_d_addr;
    h_rd[cyc]     = e_if_gnt || (e_d_gnt && tb_d_we == 4'b0000);
    h_own_if[cyc] = e_if_gnt;
    h_data[cyc]   = mm[a];
    if (e_d_gnt && tb_d_we != 4'b0000)
      for (int b = 0; b < 4; b++) if (tb_d_we[b]) mm[tb_d_addr][b*8 +: 8] = tb_d_wdata[b*8 +: 8];
    for (int k = 0; k < 2; k++) begin
      if (e_ifv[k]) hold_if[k] = e_ifd[k];
      if (e_dv[k])  hold_d[k]  = e_dd[k];
    end
    if (e_if_gnt || !tb_if_req) m_starve = 0;
    else if (e_d_gnt && m_starve < STARVE_MAX) m_starve = m_starve + 1;
    cyc = cyc + 1;
  endtask

  task automatic model_reset_cycle();
    h_rd[cyc] = 1'b0; h_flush[cyc] = 1'b0; cyc = cyc + 1;
  endtask

  task automatic model_release();
    m_starve = 0; epoch = cyc;
    for (int k = 0; k < 2; k++) begin hold_if[k] = '0; hold_d[k] = '0; end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit ir, input logic [4:0] ia, input bit fl,
                       input bit dr, input logic [3:0] we, input logic [4:0] da,
                       input logic [31:0] wd);
    tb_if_req = ir; tb_if_addr = ia; tb_if_flush = fl;
    tb_d_req = dr; tb_d_we = we; tb_d_addr = da; tb_d_wdata = wd;
  endtask

  task automatic step_begin();
    @(negedge clk);
    model_expect();
  endtask

  task automatic step_end();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (n) begin step_begin(); step_end(); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; sram_load = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus0.if_gnt, bus0.d_gnt, bus0.mem_cs, bus0.if_stall} !== 4'b0) begin
        n_fail++; $display("FAIL reset_grants: got %b want 0000", {bus0.if_gnt, bus0.d_gnt, bus0.mem_cs, bus0.if_stall});
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({o_ifv[k], o_dv[k], o_ifd[k], o_dd[k]} !== 66'd0) begin
          n_fail++; $display("FAIL reset_resp[%0d]: got %b %b %h %h want all zero", k, o_ifv[k], o_dv[k], o_ifd[k], o_dd[k]);
        end
      end
      model_reset_cycle();
      @(posedge clk); #1;
    end
    sram_load = 1'b0; rst = 1'b1;
    model_release();
  endtask

  task automatic test_fetch_stream();
    for (int i = 0; i < 7; i++) begin
      drive(i < 3, 5'(i), 0, 0, 0, 0, 0);
      step_begin();
      n_cmp++;
      if (bus0.if_gnt !== (i < 3) || bus0.if_stall !== 1'b0) begin
        n_fail++; $display("FAIL fetch_gnt c%0d: got gnt=%b stall=%b want gnt=%b stall=0", i, bus0.if_gnt, bus0.if_stall, i < 3);
      end
      n_cmp++;
      if (o_ifv[0] !== (i >= 1 && i <= 3)) begin
        n_fail++; $display("FAIL fetch_rvalid_lat1 c%0d: got %b want %b", i, o_ifv[0], (i >= 1 && i <= 3));
      end
      if (i >= 1 && i <= 3) begin
        n_cmp++;
        if (o_ifd[0] !== mm[i-1]) begin
          n_fail++; $display("FAIL fetch_rdata_lat1 c%0d: got %h want %h", i, o_ifd[0], mm[i-1]);
        end
      end
      n_cmp++;
      if (o_ifv[1] !== e_ifv[1] || o_ifd[1] !== e_ifd[1]) begin
        n_fail++; $display("FAIL fetch_lat3 c%0d: got %b/%h want %b/%h", i, o_ifv[1], o_ifd[1], e_ifv[1], e_ifd[1]);
      end
      step_end();
    end
  endtask

  task automatic test_contention();
    drive(1, 5, 0, 1, 4'b0000, 9, 0);
    step_begin();
    n_cmp++;
    if (bus0.d_gnt !== 1'b1 || bus0.if_stall !== 1'b1 || bus0.mem_addr !== 14'd9) begin
      n_fail++; $display("FAIL contend_c0: got d_gnt=%b stall=%b addr=%0d want 1 1 9", bus0.d_gnt, bus0.if_stall, bus0.mem_addr);
    end
    step_end();
    drive(1, 5, 0, 0, 0, 0, 0);
    step_begin();
    n_cmp++;
    if (bus0.if_gnt !== 1'b1 || o_dv[0] !== 1'b1 || o_dd[0] !== mm[9]) begin
      n_fail++; $display("FAIL contend_c1: got if_gnt=%b d_rvalid=%b d_rdata=%h want 1 1 %h", bus0.if_gnt, o_dv[0], o_dd[0], mm[9]);
    end
    step_end();
    drive(0, 0, 0, 0, 0, 0, 0);
    step_begin();
    n_cmp++;
    if (o_ifv[0] !== 1'b1 || o_ifd[0] !== mm[5]) begin
      n_fail++; $display("FAIL contend_c2: got if_rvalid=%b if_rdata=%h want 1 %h", o_ifv[0], o_ifd[0], mm[5]);
    end
    step_end();
    idle(4);
  endtask

  task automatic test_starvation();
    logic [5:0] exp_d;
    exp_d = 6'b101111;  // bit i = expected d_gnt in cycle i
    for (int i = 0; i < 6; i++) begin
      drive(1, 5'($urandom_range(0, 31)), 0, 1, 4'b0000, 5'($urandom_range(0, 31)), 0);
      step_begin();
      n_cmp++;
      if (bus0.d_gnt !== exp_d[i] || bus0.if_gnt !== !exp_d[i] || bus1.d_gnt !== exp_d[i]) begin
        n_fail++; $display("FAIL starve c%0d: got d_gnt=%b if_gnt=%b want d_gnt=%b", i, bus0.d_gnt, bus0.if_gnt, exp_d[i]);
      end
      step_end();
    end
    idle(4);
  endtask

  task automatic test_flush();
    logic [31:0] prior;
    prior = hold_if[1];
    for (int i = 0; i < 7; i++) begin
      drive(i <= 3, 5'(10 + i), i == 3, 0, 0, 0, 0);
      step_begin();
      if (i == 3) begin
        n_cmp++;
        if (bus0.if_gnt !== 1'b0 || bus0.mem_cs !== 1'b0 || o_ifv[0] !== 1'b0) begin
          n_fail++; $display("FAIL flush_c3: got if_gnt=%b cs=%b rvalid_lat1=%b want 0 0 0", bus0.if_gnt, bus0.mem_cs, o_ifv[0]);
        end
      end
      if (i == 1 || i == 2) begin
        n_cmp++;
        if (o_ifv[0] !== 1'b1 || o_ifd[0] !== mm[10 + i - 1]) begin
          n_fail++; $display("FAIL flush_lat1 c%0d: got %b/%h want 1/%h", i, o_ifv[0], o_ifd[0], mm[10 + i - 1]);
        end
      end
      n_cmp++;
      if (o_ifv[1] !== 1'b0 || o_ifd[1] !== prior) begin
        n_fail++; $display("FAIL flush_lat3 c%0d: got %b/%h want 0/%h", i, o_ifv[1], o_ifd[1], prior);
      end
      step_end();
    end
  endtask

  task automatic test_write_merge();
    logic [31:0] old;
    old = mm[7];
    for (int i = 0; i < 5; i++) begin
      if (i == 0)      drive(0, 0, 0, 1, 4'b0011, 7, 32'hAABBCCDD);
      else if (i == 1) drive(0, 0, 0, 1, 4'b0000, 7, 0);
      else             drive(0, 0, 0, 0, 0, 0, 0);
      step_begin();
      if (i == 0) begin
        n_cmp++;
        if (bus0.mem_we !== 4'b0011 || bus0.d_gnt !== 1'b1 || bus0.mem_cs !== 1'b1 || bus0.mem_wdata !== 32'hAABBCCDD) begin
          n_fail++; $display("FAIL write_issue: got we=%b gnt=%b cs=%b wdata=%h", bus0.mem_we, bus0.d_gnt, bus0.mem_cs, bus0.mem_wdata);
        end
      end
      if (i == 1 || i == 2) begin
        n_cmp++;
        if (o_dv[0] !== (i == 2) || (i == 2 && o_dd[0] !== {old[31:16], 16'hCCDD})) begin
          n_fail++; $display("FAIL write_merge c%0d: got %b/%h want %b/%h", i, o_dv[0], o_dd[0], i == 2, {old[31:16], 16'hCCDD});
        end
      end
      n_cmp++;
      if (o_dv[1] !== e_dv[1] || o_dd[1] !== e_dd[1]) begin
        n_fail++; $display("FAIL write_lat3 c%0d: got %b/%h want %b/%h", i, o_dv[1], o_dd[1], e_dv[1], e_dd[1]);
      end
      step_end();
    end
  endtask

  task automatic test_reset_midstream();
    drive(1, 3, 0, 0, 0, 0, 0);
    step_begin(); step_end();
    drive(0, 0, 0, 1, 4'b0000, 4, 0);
    step_begin(); step_end();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({o_ifv[k], o_dv[k], o_ifd[k], o_dd[k]} !== 66'd0) begin
          n_fail++; $display("FAIL midreset_in[%0d] c%0d: got %b %b %h %h want all zero", k, i, o_ifv[k], o_dv[k], o_ifd[k], o_dd[k]);
        end
      end
      model_reset_cycle();
      @(posedge clk); #1;
    end
    rst = 1'b1;
    model_release();
    for (int i = 0; i < 4; i++) begin
      step_begin();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if ({o_ifv[k], o_dv[k], o_ifd[k], o_dd[k]} !== 66'd0) begin
          n_fail++; $display("FAIL midreset_after[%0d] c%0d: got %b %b %h %h want all zero", k, i, o_ifv[k], o_dv[k], o_ifd[k], o_dd[k]);
        end
      end
      step_end();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom_range(0, 9) == 0,
            $urandom_range(0, 1) == 1, ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
            5'($urandom_range(0, 31)), $urandom);
      step_begin();
      n_cmp++;
      if (bus0.if_gnt !== e_if_gnt || bus0.d_gnt !== e_d_gnt || bus0.if_stall !== (tb_if_req && !e_if_gnt) ||
          bus0.mem_cs !== (e_if_gnt || e_d_gnt) || bus1.if_gnt !== e_if_gnt || bus1.d_gnt !== e_d_gnt) begin
        n_fail++; $display("FAIL rand_gnt c%0d: got if=%b d=%b stall=%b cs=%b want if=%b d=%b", i,
                           bus0.if_gnt, bus0.d_gnt, bus0.if_stall, bus0.mem_cs, e_if_gnt, e_d_gnt);
      end
      if (e_if_gnt || e_d_gnt) begin
        n_cmp++;
        if (bus0.mem_addr[4:0] !== (e_if_gnt ? tb_if_addr : tb_d_addr) || bus0.mem_we !== (e_d_gnt ? tb_d_we : 4'b0000)) begin
          n_fail++; $display("FAIL rand_mem c%0d: got addr=%0d we=%b", i, bus0.mem_addr, bus0.mem_we);
        end
      end
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (o_ifv[k] !== e_ifv[k] || o_ifd[k] !== e_ifd[k] || o_dv[k] !== e_dv[k] || o_dd[k] !== e_dd[k]) begin
          n_fail++; $display("FAIL rand_resp[%0d] c%0d: got %b/%h %b/%h want %b/%h %b/%h", k, i,
                             o_ifv[k], o_ifd[k], o_dv[k], o_dd[k], e_ifv[k], e_ifd[k], e_dv[k], e_dd[k]);
        end
      end
      step_end();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; epoch = 0; m_starve = 0;
    for (int i = 0; i < HIST; i++) begin h_rd[i] = 1'b0; h_own_if[i] = 1'b0; h_flush[i] = 1'b0; end
    for (int i = 0; i < 32; i++) begin init_val[i] = $urandom; mm[i] = init_val[i]; end
    for (int k = 0; k < 2; k++) begin hold_if[k] = '0; hold_d[k] = '0; end
    test_reset();
    test_fetch_stream();
    test_contention();
    test_starvation();
    test_flush();
    test_write_merge();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
